exec_mem_unit: RTL and testbench

//  Execute/memory datapath core of the 5-stage MIPS pipeline: ALU-control decoder,
//  32-bit ALU and word-addressed data memory in one block. Fed by EX pipeline regs
//  (ALUop, funct, operands); ALU result is the DMEM byte address. Read data goes to WB.
//  All sequential logic on negedge SYS_clk, matching the pipeline registers.

---
 rtl/exec_mem_unit.sv | 130 +++++++++++++
 tb/tb_exec_mem_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// exec_mem_unit
//   Execute/memory datapath core of the 5-stage MIPS pipeline. It holds the
//   ALU-control decoder, the 32-bit ALU and a word-addressed data memory.
//   The ALU result doubles as the DMEM byte address. Load data goes on to WB.
//   All sequential state updates on the falling edge of SYS_clk.
//
// Ports
//   SYS_clk     in   1   system clock; DMEM writes on the falling edge
//   SYS_reset   in   1   asynchronous, active-high; clears the whole DMEM
//   ALUop       in   2   ALU op class from main control
//   funct       in   6   instruction[5:0]
//   alu_a       in   32  operand A (rs)
//   alu_b       in   32  operand B (rt or sign-extended immediate)
//   mem_wdata   in   32  store data
//   mem_write   in   1   store enable
//   mem_read    in   1   load enable
//   alu_ctrl    out  4   decoded ALU operation
//   alu_result  out  32  ALU result; also the DMEM byte address
//   status_out  out  4   {zero, negative, overflow, carry}
//   mem_rdata   out  32  load data (0 when mem_read is low)
module exec_mem_unit #(
  parameter int DMEM_WORDS = 256,
  parameter int ADDR_BITS  = 8
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  ALUop,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic [3:0]  status_out,
  output logic [31:0] mem_rdata
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_INV = 4'b1111;

  // ALU control decode
  always_comb begin
    alu_ctrl = CTRL_INV;
    case (ALUop)
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      2'b11: alu_ctrl = CTRL_OR;
      default: begin
        case (funct)
          6'b100000, 6'b100001: alu_ctrl = CTRL_ADD;
          6'b100010, 6'b100011: alu_ctrl = CTRL_SUB;
          6'b100100:            alu_ctrl = CTRL_AND;
          6'b100101:            alu_ctrl = CTRL_OR;
          6'b100110:            alu_ctrl = CTRL_XOR;
          6'b100111:            alu_ctrl = CTRL_NOR;
          6'b101010:            alu_ctrl = CTRL_SLT;
          default:              alu_ctrl = CTRL_INV;
        endcase
      end
    endcase
  end

  // 33-bit adders so bit 32 is the carry-out. Subtraction is a + ~b + 1,
  // which makes carry = 1 mean "no borrow".
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_ext = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;

  logic overflow;
  logic carry;

  always_comb begin
    alu_result = 32'h0;
    overflow   = 1'b0;
    carry      = 1'b0;
    case (alu_ctrl)
      CTRL_AND: alu_result = alu_a & alu_b;
      CTRL_OR:  alu_result = alu_a | alu_b;
      CTRL_XOR: alu_result = alu_a ^ alu_b;
      CTRL_NOR: alu_result = ~(alu_a | alu_b);
      CTRL_ADD: begin
        alu_result = sum_ext[31:0];
        carry      = sum_ext[32];
        overflow   = (alu_a[31] == alu_b[31]) && (sum_ext[31] != alu_a[31]);
      end
      CTRL_SUB: begin
        alu_result = diff_ext[31:0];
        carry      = diff_ext[32];
        overflow   = (alu_a[31] != alu_b[31]) && (diff_ext[31] != alu_a[31]);
      end
      // True signed compare; the difference MSB alone is wrong on overflow.
      CTRL_SLT: alu_result = {31'h0, ($signed(alu_a) < $signed(alu_b))};
      default:  alu_result = 32'h0;
    endcase
  end

  // Invalid codes give result 0, so zero=1 falls out naturally.
  assign status_out = {(alu_result == 32'h0), alu_result[31], overflow, carry};

  // Data memory: byte address -> word index, low two bits and upper bits ignored.
  logic [ADDR_BITS-1:0] word_idx;
  logic [31:0]          mem_reg [DMEM_WORDS];

  assign word_idx = alu_result[ADDR_BITS+1:2];

  // Whole-array asynchronous clear, so this is register storage rather than
  // a block RAM. Reset also masks any write in progress.
  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_reg[i] <= 32'h0;
      end
    end else if (mem_write) begin
      mem_reg[word_idx] <= mem_wdata;
    end
  end

  // Combinational read shows the pre-edge contents during a same-cycle write.
  assign mem_rdata = mem_read ? mem_reg[word_idx] : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed testbench for exec_mem_unit. Inputs change shortly after the
// rising edge; outputs are sampled 1 time unit later, well away from the
// falling edge where DMEM writes happen.
module tb_exec_mem_unit;

  logic        SYS_clk;
  logic        SYS_reset;
  logic [1:0]  ALUop;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  status_out;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  exec_mem_unit #(.DMEM_WORDS(256), .ADDR_BITS(8)) dut (
    .SYS_clk    (SYS_clk),
    .SYS_reset  (SYS_reset),
    .ALUop      (ALUop),
    .funct      (funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .status_out (status_out),
    .mem_rdata  (mem_rdata)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  // Drive one input vector just after a rising edge and let it settle.
  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wd, input logic we, input logic re);
    @(posedge SYS_clk);
    ALUop = op; funct = fn; alu_a = a; alu_b = b;
    mem_wdata = wd; mem_write = we; mem_read = re;
    #1;
  endtask

  task automatic test_reset;
    SYS_reset = 1'b1;
    drive(2'b00, 6'h0, 32'h0, 32'h20, 32'h1234_5678, 1'b1, 1'b1);
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want %h", mem_rdata, 32'h0);
    end
    vectors++;
    if (alu_result !== 32'h20) begin
      miscompares++;
      $display("FAIL reset_alu_result: got %h want %h", alu_result, 32'h20);
    end
    @(negedge SYS_clk); #2;
    mem_write = 1'b0;
    SYS_reset = 1'b0;
    #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_write_blocked: got %h want %h", mem_rdata, 32'h0);
    end
    $display("test_reset done");
  endtask

  task automatic test_spec_vectors;
    drive(2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_ctrl, alu_result, status_out} !== {4'b0010, 32'd12, 4'b0000}) begin
      miscompares++;
      $display("FAIL add_5_7: got ctrl=%b res=%h st=%b want ctrl=0010 res=0000000c st=0000",
               alu_ctrl, alu_result, status_out);
    end
    drive(2'b10, 6'b100010, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_result, status_out} !== {32'h0, 4'b1001}) begin
      miscompares++;
      $display("FAIL sub_3_3: got res=%h st=%b want res=00000000 st=1001", alu_result, status_out);
    end
    drive(2'b10, 6'b100010, 32'd0, 32'd1, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_result, status_out} !== {32'hFFFF_FFFF, 4'b0100}) begin
      miscompares++;
      $display("FAIL sub_0_1: got res=%h st=%b want res=ffffffff st=0100", alu_result, status_out);
    end
    drive(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_result, status_out} !== {32'h8000_0000, 4'b0110}) begin
      miscompares++;
      $display("FAIL add_ovf: got res=%h st=%b want res=80000000 st=0110", alu_result, status_out);
    end
    drive(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_result, status_out} !== {32'h0, 4'b1001}) begin
      miscompares++;
      $display("FAIL add_carry: got res=%h st=%b want res=00000000 st=1001", alu_result, status_out);
    end
    drive(2'b10, 6'b100010, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_result, status_out} !== {32'h7FFF_FFFF, 4'b0011}) begin
      miscompares++;
      $display("FAIL sub_ovf: got res=%h st=%b want res=7fffffff st=0011", alu_result, status_out);
    end
    drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_ctrl, alu_result, status_out} !== {4'b0111, 32'h1, 4'b0000}) begin
      miscompares++;
      $display("FAIL slt_neg: got ctrl=%b res=%h st=%b want ctrl=0111 res=00000001 st=0000",
               alu_ctrl, alu_result, status_out);
    end
    // a-b overflows here, so the difference MSB would give the wrong answer.
    drive(2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (alu_result !== 32'h1) begin
      miscompares++;
      $display("FAIL slt_true_sign: got %h want %h", alu_result, 32'h1);
    end
    drive(2'b10, 6'b111111, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({alu_ctrl, alu_result, status_out} !== {4'b1111, 32'h0, 4'b1000}) begin
      miscompares++;
      $display("FAIL invalid_funct: got ctrl=%b res=%h st=%b want ctrl=1111 res=00000000 st=1000",
               alu_ctrl, alu_result, status_out);
    end
    $display("test_spec_vectors done");
  endtask

  // a=0xC, b=0xA through every decoded operation.
  task automatic test_decode_table;
    logic [1:0]  op_t  [12];
    logic [5:0]  fn_t  [12];
    logic [3:0]  ctl_t [12];
    logic [31:0] res_t [12];
    logic [3:0]  st_t  [12];
    op_t[0]  = 2'b10; fn_t[0]  = 6'b100000; ctl_t[0]  = 4'b0010; res_t[0]  = 32'h16;        st_t[0]  = 4'b0000;
    op_t[1]  = 2'b10; fn_t[1]  = 6'b100001; ctl_t[1]  = 4'b0010; res_t[1]  = 32'h16;        st_t[1]  = 4'b0000;
    op_t[2]  = 2'b10; fn_t[2]  = 6'b100010; ctl_t[2]  = 4'b0110; res_t[2]  = 32'h2;         st_t[2]  = 4'b0001;
    op_t[3]  = 2'b10; fn_t[3]  = 6'b100011; ctl_t[3]  = 4'b0110; res_t[3]  = 32'h2;         st_t[3]  = 4'b0001;
    op_t[4]  = 2'b10; fn_t[4]  = 6'b100100; ctl_t[4]  = 4'b0000; res_t[4]  = 32'h8;         st_t[4]  = 4'b0000;
    op_t[5]  = 2'b10; fn_t[5]  = 6'b100101; ctl_t[5]  = 4'b0001; res_t[5]  = 32'hE;         st_t[5]  = 4'b0000;
    op_t[6]  = 2'b10; fn_t[6]  = 6'b100110; ctl_t[6]  = 4'b0011; res_t[6]  = 32'h6;         st_t[6]  = 4'b0000;
    op_t[7]  = 2'b10; fn_t[7]  = 6'b100111; ctl_t[7]  = 4'b1100; res_t[7]  = 32'hFFFF_FFF1; st_t[7]  = 4'b0100;
    op_t[8]  = 2'b10; fn_t[8]  = 6'b101010; ctl_t[8]  = 4'b0111; res_t[8]  = 32'h0;         st_t[8]  = 4'b1000;
    op_t[9]  = 2'b00; fn_t[9]  = 6'b000000; ctl_t[9]  = 4'b0010; res_t[9]  = 32'h16;        st_t[9]  = 4'b0000;
    op_t[10] = 2'b01; fn_t[10] = 6'b100100; ctl_t[10] = 4'b0110; res_t[10] = 32'h2;         st_t[10] = 4'b0001;
    op_t[11] = 2'b11; fn_t[11] = 6'b100000; ctl_t[11] = 4'b0001; res_t[11] = 32'hE;         st_t[11] = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      drive(op_t[i], fn_t[i], 32'hC, 32'hA, 32'h0, 1'b0, 1'b0);
      vectors++;
      if ({alu_ctrl, alu_result, status_out} !== {ctl_t[i], res_t[i], st_t[i]}) begin
        miscompares++;
        $display("FAIL decode[%0d] op=%b fn=%b: got ctrl=%b res=%h st=%b want ctrl=%b res=%h st=%b",
                 i, op_t[i], fn_t[i], alu_ctrl, alu_result, status_out, ctl_t[i], res_t[i], st_t[i]);
      end
    end
    $display("test_decode_table done");
  endtask

  task automatic test_store_load;
    drive(2'b00, 6'h0, 32'h0, 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(negedge SYS_clk); #1;
    mem_write = 1'b0; mem_read = 1'b1; #1;
    vectors++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_addr8: got %h want %h", mem_rdata, 32'hDEAD_BEEF);
    end
    alu_b = 32'h9; #1;
    vectors++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_addr9: got %h want %h", mem_rdata, 32'hDEAD_BEEF);
    end
    alu_b = 32'h408; #1;
    vectors++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_alias_408: got %h want %h", mem_rdata, 32'hDEAD_BEEF);
    end
    alu_b = 32'hC; #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL load_neighbour_c: got %h want %h", mem_rdata, 32'h0);
    end
    alu_b = 32'h8; mem_read = 1'b0; #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL read_disabled: got %h want %h", mem_rdata, 32'h0);
    end
    $display("test_store_load done");
  endtask

  // Read and write of the same word in one cycle: old data until the edge.
  task automatic test_back_to_back;
    drive(2'b00, 6'h0, 32'h400, 32'h8, 32'hCAFE_F00D, 1'b1, 1'b1);
    vectors++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rw_pre_edge: got %h want %h", mem_rdata, 32'hDEAD_BEEF);
    end
    @(negedge SYS_clk); #1;
    mem_write = 1'b0; #1;
    vectors++;
    if (mem_rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rw_post_edge: got %h want %h", mem_rdata, 32'hCAFE_F00D);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset;
    drive(2'b00, 6'h0, 32'h0, 32'h10, 32'h1357_9BDF, 1'b1, 1'b1);
    @(negedge SYS_clk); #1;
    mem_write = 1'b0; #1;
    vectors++;
    if (mem_rdata !== 32'h1357_9BDF) begin
      miscompares++;
      $display("FAIL pre_reset_store: got %h want %h", mem_rdata, 32'h1357_9BDF);
    end
    // Pulse reset between edges: memory must clear without a clock edge.
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b1; #1;
    SYS_reset = 1'b0; #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL async_clear: got %h want %h", mem_rdata, 32'h0);
    end
    alu_b = 32'h8; #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL async_clear_other: got %h want %h", mem_rdata, 32'h0);
    end
    // Write attempted across a falling edge while reset is held.
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b1; alu_b = 32'h10; mem_wdata = 32'hFFFF_0000; mem_write = 1'b1;
    @(negedge SYS_clk); #2;
    mem_write = 1'b0;
    SYS_reset = 1'b0; #1;
    vectors++;
    if (mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL write_in_reset: got %h want %h", mem_rdata, 32'h0);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    SYS_reset = 1'b1;
    ALUop = 2'b00; funct = 6'h0; alu_a = 32'h0; alu_b = 32'h0;
    mem_wdata = 32'h0; mem_write = 1'b0; mem_read = 1'b0;
    test_reset();
    test_spec_vectors();
    test_decode_table();
    test_store_load();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
